// File: rtl/time_set_uart_rx.sv
// Serial time-setting receiver: 8N1 UART bytes carrying "T" HHMMSS CR are
// range-checked and presented as packed-BCD preset values with a load strobe.
module time_set_uart_rx #(
    parameter int CLK_Freq = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK_50,
    input  logic       CR,
    input  logic       RXD,
    output logic [7:0] Set_Hr,
    output logic [7:0] Set_Min,
    output logic [7:0] Set_Sec,
    output logic       LoadTime,
    output logic       FrameErr,
    output logic       ParseErr
);
    localparam int DIV = CLK_Freq / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    // ------------------------------------------------------------------
    // Synchroniser and start-edge qualification
    // ------------------------------------------------------------------
    logic       rx_s1, rx_s2, rx_prev, armed;
    logic [1:0] fill;

    // armed stays low until the synchronised line has genuinely been seen
    // high, so a line held low through reset cannot fake a start edge.
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_s1   <= RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            fill    <= {fill[0], 1'b1};
            armed   <= armed | (fill[1] & rx_s2);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            byte_vld;
    logic            tick;

    assign tick = (cnt == '0);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (armed && rx_prev && !rx_s2) rx_next = START;
            START: if (tick) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 3'd7) rx_next = STOP;
            STOP:  if (tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // cnt is preloaded while idle so the start bit is sampled at mid-bit
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            rx_state <= IDLE;
            cnt      <= HALF_M1;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            byte_vld <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == IDLE)
                cnt <= HALF_M1;
            else if (tick)
                cnt <= FULL_M1;
            else
                cnt <= cnt - 1'b1;
            if (rx_state != DATA)
                bit_idx <= 3'd0;
            else if (tick)
                bit_idx <= bit_idx + 3'd1;
            if (rx_state == DATA && tick)
                shreg <= {rx_s2, shreg[7:1]};
            byte_vld <= (rx_state == STOP) && tick && rx_s2;
            FrameErr <= (rx_state == STOP) && tick && !rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {WAIT_T, D0, D1, D2, D3, D4, D5, WAIT_CR} ps_t;

    ps_t         ps, ps_next;
    logic [23:0] hold;
    logic [3:0]  nib;
    logic        is_digit, range_ok, hold_we, do_load, do_perr;

    assign nib      = shreg[3:0];
    assign is_digit = (shreg >= 8'h30) && (shreg <= 8'h39);

    always_comb begin
        range_ok = 1'b1;
        case (ps)
            D0:      range_ok = (nib <= 4'd2);
            D1:      range_ok = (hold[23:20] != 4'd2) || (nib <= 4'd3);
            D2, D4:  range_ok = (nib <= 4'd5);
            default: range_ok = 1'b1;
        endcase
    end

    always_comb begin
        ps_next = ps;
        hold_we = 1'b0;
        do_load = 1'b0;
        do_perr = 1'b0;
        if (FrameErr) begin
            ps_next = WAIT_T;
        end else if (byte_vld) begin
            if (shreg == 8'h54) begin
                ps_next = D0;
            end else begin
                case (ps)
                    WAIT_T: ps_next = WAIT_T;
                    WAIT_CR: begin
                        ps_next = WAIT_T;
                        if (shreg == 8'h0D) do_load = 1'b1;
                        else                do_perr = 1'b1;
                    end
                    default: begin
                        if (is_digit && range_ok) begin
                            hold_we = 1'b1;
                            ps_next = ps_t'(ps + 3'd1);
                        end else begin
                            do_perr = 1'b1;
                            ps_next = WAIT_T;
                        end
                    end
                endcase
            end
        end
    end

    // hold is private to the parser; Set_* only move on a completed command
    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            ps       <= WAIT_T;
            hold     <= 24'h000000;
            Set_Hr   <= 8'h00;
            Set_Min  <= 8'h00;
            Set_Sec  <= 8'h00;
            LoadTime <= 1'b0;
            ParseErr <= 1'b0;
        end else begin
            ps       <= ps_next;
            LoadTime <= do_load;
            ParseErr <= do_perr;
            if (hold_we) begin
                case (ps)
                    D0:      hold[23:20] <= nib;
                    D1:      hold[19:16] <= nib;
                    D2:      hold[15:12] <= nib;
                    D3:      hold[11:8]  <= nib;
                    D4:      hold[7:4]   <= nib;
                    D5:      hold[3:0]   <= nib;
                    default: hold        <= hold;
                endcase
            end
            if (do_load) begin
                Set_Hr  <= hold[23:16];
                Set_Min <= hold[15:8];
                Set_Sec <= hold[7:0];
            end
        end
    end

endmodule

// File: tb/tb_time_set_uart_rx.sv
// Directed bench for time_set_uart_rx at DIV = 10: bit-bangs UART frames and
// checks load/error pulses, their latency and the preset values.
module tb_time_set_uart_rx;
    logic       CLK_50 = 1'b0;
    logic       CR     = 1'b1;
    logic       RXD    = 1'b1;
    logic [7:0] Set_Hr, Set_Min, Set_Sec;
    logic       LoadTime, FrameErr, ParseErr;

    time_set_uart_rx #(.CLK_Freq(50000000), .BAUD(5000000)) dut (
        .CLK_50(CLK_50), .CR(CR), .RXD(RXD),
        .Set_Hr(Set_Hr), .Set_Min(Set_Min), .Set_Sec(Set_Sec),
        .LoadTime(LoadTime), .FrameErr(FrameErr), .ParseErr(ParseErr)
    );

    always #5 CLK_50 = ~CLK_50;

    int cyc = 0;
    always @(posedge CLK_50) cyc <= cyc + 1;

    // pulse monitor, sampled on the falling edge
    int lt_n = 0, fe_n = 0, pe_n = 0, both_n = 0;
    int lt_cyc = 0, fe_cyc = 0, pe_cyc = 0;
    always @(negedge CLK_50) begin
        if (LoadTime) begin lt_n++; lt_cyc = cyc; end
        if (FrameErr) begin fe_n++; fe_cyc = cyc; end
        if (ParseErr) begin pe_n++; pe_cyc = cyc; end
        if (int'(LoadTime) + int'(FrameErr) + int'(ParseErr) > 1) both_n++;
    end

    int n_cmp = 0, n_bad = 0;
    int start_cyc = 0;
    int lt0, fe0, pe0;

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_50);
    endtask

    task automatic snap();
        lt0 = lt_n; fe0 = fe_n; pe0 = pe_n;
    endtask

    // Frame timing from start-bit drive: 2 sync flops + 1 edge register puts
    // START entry at posedge 3, stop sample at 3+5+90 = 98; FrameErr and the
    // byte strobe register there, LoadTime/ParseErr one edge later (99).
    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        RXD = 1'b0; idle(10);
        for (int i = 0; i < 8; i++) begin RXD = b[i]; idle(10); end
        RXD = stop; idle(10);
        RXD = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic test_reset();
        CR = 1'b1; idle(3);
        n_cmp++; if (Set_Hr !== 8'h00)  begin n_bad++; $display("FAIL rst_hr got %h exp 00", Set_Hr); end
        n_cmp++; if (Set_Min !== 8'h00) begin n_bad++; $display("FAIL rst_min got %h exp 00", Set_Min); end
        n_cmp++; if (Set_Sec !== 8'h00) begin n_bad++; $display("FAIL rst_sec got %h exp 00", Set_Sec); end
        n_cmp++; if (LoadTime !== 1'b0) begin n_bad++; $display("FAIL rst_lt got %b exp 0", LoadTime); end
        n_cmp++; if (FrameErr !== 1'b0) begin n_bad++; $display("FAIL rst_fe got %b exp 0", FrameErr); end
        n_cmp++; if (ParseErr !== 1'b0) begin n_bad++; $display("FAIL rst_pe got %b exp 0", ParseErr); end
        CR = 1'b0; idle(20);
        n_cmp++; if (lt_n + fe_n + pe_n !== 0) begin n_bad++; $display("FAIL rst_idle_pulses got %0d exp 0", lt_n + fe_n + pe_n); end
    endtask

    task automatic test_valid();
        snap();
        send_str("T235959"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (lt_n - lt0 !== 1) begin n_bad++; $display("FAIL valid_lt_cnt got %0d exp 1", lt_n - lt0); end
        n_cmp++; if (lt_cyc - start_cyc !== 99) begin n_bad++; $display("FAIL valid_lt_lat got %0d exp 99", lt_cyc - start_cyc); end
        n_cmp++; if (Set_Hr !== 8'h23)  begin n_bad++; $display("FAIL valid_hr got %h exp 23", Set_Hr); end
        n_cmp++; if (Set_Min !== 8'h59) begin n_bad++; $display("FAIL valid_min got %h exp 59", Set_Min); end
        n_cmp++; if (Set_Sec !== 8'h59) begin n_bad++; $display("FAIL valid_sec got %h exp 59", Set_Sec); end
        n_cmp++; if ((fe_n - fe0) + (pe_n - pe0) !== 0) begin n_bad++; $display("FAIL valid_err got %0d exp 0", (fe_n - fe0) + (pe_n - pe0)); end
    endtask

    task automatic test_range();
        snap();
        send_str("T120000"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (lt_n - lt0 !== 1) begin n_bad++; $display("FAIL range_lt1 got %0d exp 1", lt_n - lt0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h120000) begin n_bad++; $display("FAIL range_load got %h exp 120000", {Set_Hr, Set_Min, Set_Sec}); end
        snap();
        send_str("T2"); send_byte(8'h34, 1'b1);
        n_cmp++; if (pe_n - pe0 !== 1) begin n_bad++; $display("FAIL range_pe got %0d exp 1", pe_n - pe0); end
        n_cmp++; if (pe_cyc - start_cyc !== 99) begin n_bad++; $display("FAIL range_pe_lat got %0d exp 99", pe_cyc - start_cyc); end
        send_str("5900"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (pe_n - pe0 !== 1) begin n_bad++; $display("FAIL range_pe_total got %0d exp 1", pe_n - pe0); end
        n_cmp++; if (lt_n - lt0 !== 0) begin n_bad++; $display("FAIL range_no_lt got %0d exp 0", lt_n - lt0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h120000) begin n_bad++; $display("FAIL range_hold got %h exp 120000", {Set_Hr, Set_Min, Set_Sec}); end
    endtask

    task automatic test_restart();
        snap();
        send_str("T07T083015"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (lt_n - lt0 !== 1) begin n_bad++; $display("FAIL restart_lt got %0d exp 1", lt_n - lt0); end
        n_cmp++; if ((fe_n - fe0) + (pe_n - pe0) !== 0) begin n_bad++; $display("FAIL restart_err got %0d exp 0", (fe_n - fe0) + (pe_n - pe0)); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h083015) begin n_bad++; $display("FAIL restart_load got %h exp 083015", {Set_Hr, Set_Min, Set_Sec}); end
    endtask

    task automatic test_frame();
        snap();
        send_byte(8'h54, 1'b0); idle(10);
        n_cmp++; if (fe_n - fe0 !== 1) begin n_bad++; $display("FAIL frame_fe got %0d exp 1", fe_n - fe0); end
        n_cmp++; if (fe_cyc - start_cyc !== 98) begin n_bad++; $display("FAIL frame_fe_lat got %0d exp 98", fe_cyc - start_cyc); end
        send_str("T010203"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (lt_n - lt0 !== 1) begin n_bad++; $display("FAIL frame_lt got %0d exp 1", lt_n - lt0); end
        n_cmp++; if (fe_n - fe0 !== 1) begin n_bad++; $display("FAIL frame_fe_total got %0d exp 1", fe_n - fe0); end
        n_cmp++; if (pe_n - pe0 !== 0) begin n_bad++; $display("FAIL frame_pe got %0d exp 0", pe_n - pe0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h010203) begin n_bad++; $display("FAIL frame_load got %h exp 010203", {Set_Hr, Set_Min, Set_Sec}); end
    endtask

    task automatic test_glitch_reset();
        logic [7:0] d3;
        snap();
        RXD = 1'b0; idle(3); RXD = 1'b1; idle(40);
        n_cmp++; if ((lt_n - lt0) + (fe_n - fe0) + (pe_n - pe0) !== 0) begin n_bad++; $display("FAIL glitch_pulses got %0d exp 0", (lt_n - lt0) + (fe_n - fe0) + (pe_n - pe0)); end
        // "T12" then '3' (0x33) with reset landing in the middle of bit 3
        d3 = 8'h33;
        send_str("T12");
        RXD = 1'b0; idle(10);
        for (int i = 0; i < 3; i++) begin RXD = d3[i]; idle(10); end
        RXD = d3[3]; idle(5);
        CR = 1'b1; idle(2);
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h000000) begin n_bad++; $display("FAIL glitch_rst_set got %h exp 000000", {Set_Hr, Set_Min, Set_Sec}); end
        n_cmp++; if ({LoadTime, FrameErr, ParseErr} !== 3'b000) begin n_bad++; $display("FAIL glitch_rst_pulse got %b exp 000", {LoadTime, FrameErr, ParseErr}); end
        CR = 1'b0; idle(3);
        for (int i = 4; i < 8; i++) begin RXD = d3[i]; idle(10); end
        RXD = 1'b1; idle(10);
        snap();
        send_str("000"); send_byte(8'h0D, 1'b1); idle(30);
        n_cmp++; if (lt_n - lt0 !== 0) begin n_bad++; $display("FAIL glitch_tail_lt got %0d exp 0", lt_n - lt0); end
        n_cmp++; if (pe_n - pe0 !== 0) begin n_bad++; $display("FAIL glitch_tail_pe got %0d exp 0", pe_n - pe0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h000000) begin n_bad++; $display("FAIL glitch_tail_set got %h exp 000000", {Set_Hr, Set_Min, Set_Sec}); end
    endtask

    task automatic test_parse_err();
        snap();
        send_str("T1a3000"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (pe_n - pe0 !== 1) begin n_bad++; $display("FAIL perr_alpha got %0d exp 1", pe_n - pe0); end
        send_str("T123000X"); idle(5);
        n_cmp++; if (pe_n - pe0 !== 2) begin n_bad++; $display("FAIL perr_nocr got %0d exp 2", pe_n - pe0); end
        n_cmp++; if (lt_n - lt0 !== 0) begin n_bad++; $display("FAIL perr_no_lt got %0d exp 0", lt_n - lt0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h000000) begin n_bad++; $display("FAIL perr_hold got %h exp 000000", {Set_Hr, Set_Min, Set_Sec}); end
        send_str("T123000"); send_byte(8'h0D, 1'b1); idle(5);
        n_cmp++; if (lt_n - lt0 !== 1) begin n_bad++; $display("FAIL perr_good_lt got %0d exp 1", lt_n - lt0); end
        n_cmp++; if (pe_n - pe0 !== 2) begin n_bad++; $display("FAIL perr_good_pe got %0d exp 2", pe_n - pe0); end
        n_cmp++; if ({Set_Hr, Set_Min, Set_Sec} !== 24'h123000) begin n_bad++; $display("FAIL perr_good_load got %h exp 123000", {Set_Hr, Set_Min, Set_Sec}); end
    endtask

    initial begin
        @(negedge CLK_50);
        test_reset();
        test_valid();
        test_range();
        test_restart();
        test_frame();
        test_glitch_reset();
        test_parse_err();
        n_cmp++; if (both_n !== 0) begin n_bad++; $display("FAIL pulse_overlap got %0d exp 0", both_n); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
